// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes, ALU operand/result bus and response signals
interface alu_arbiter_if;
  logic        req0, req1, ack0, ack1;
  logic [2:0]  opc0, opc1, alu_opc;
  logic [15:0] a0, b0, a1, b1, alu_a, alu_b, alu_result, rsp_data;
  logic        alu_zero, rsp_zero, rsp_id, busy;
  modport slave (
    input  req0, opc0, a0, b0, req1, opc1, a1, b1, alu_result, alu_zero,
    output ack0, ack1, alu_a, alu_b, alu_opc, rsp_data, rsp_zero, rsp_id, busy
  );
  modport master (
    output req0, opc0, a0, b0, req1, opc1, a1, b1, alu_result, alu_zero,
    input  ack0, ack1, alu_a, alu_b, alu_opc, rsp_data, rsp_zero, rsp_id, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 16-bit ALU between two req/ack requesters
module alu_arbiter (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [2:0]  opc_q, opc_d;
  logic        zero_q, zero_d, id_q, id_d, prio_q, prio_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        win, gnt, cap;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b1;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? ((bus.req0 | bus.req1) ? EXEC : IDLE) :
              state_q == EXEC ? RESP : IDLE;
  end
  // ack is registered on leaving RESP so it lands in the cycle after, overlapping the next grant
  always_comb begin
    win    = (bus.req0 & bus.req1) ? prio_q : ~bus.req0;
    gnt    = state_q == IDLE && (bus.req0 | bus.req1);
    cap    = state_q == EXEC;
    a_d    = gnt ? (win ? bus.a1 : bus.a0) : a_q;
    b_d    = gnt ? (win ? bus.b1 : bus.b0) : b_q;
    opc_d  = gnt ? (win ? bus.opc1 : bus.opc0) : opc_q;
    id_d   = gnt ? win : id_q;
    data_d = (cap && opc_q != 3'b111) ? bus.alu_result : data_q;
    zero_d = cap ? (opc_q == 3'b111 ? data_q == 16'h0 : bus.alu_zero) : zero_q;
    prio_d = state_q == RESP ? ~id_q : prio_q;
    ack0_d = state_q == RESP && !id_q;
    ack1_d = state_q == RESP && id_q;
  end
  assign bus.alu_a    = a_q;
  assign bus.alu_b    = b_q;
  assign bus.alu_opc  = opc_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_zero = zero_q;
  assign bus.rsp_id   = id_q;
  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.busy     = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenario tasks against alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [15:0] r;
  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always_comb begin
    r = 16'h0;
    case (bus.alu_opc)
      3'b000: r = bus.alu_b;
      3'b001: r = bus.alu_a;
      3'b010: r = bus.alu_a + bus.alu_b;
      3'b011: r = bus.alu_b - bus.alu_a;
      3'b100: r = bus.alu_a & bus.alu_b;
      3'b101: r = bus.alu_a | bus.alu_b;
      3'b110: r = ~bus.alu_a;
      default: r = 16'h0;
    endcase
    bus.alu_result = r;
    bus.alu_zero   = r == 16'h0;
  end
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b1; bus.opc0 = 3'b010; bus.a0 = 16'd3; bus.b0 = 16'd5;
    @(negedge clk);
    total++; if (bus.alu_a !== 16'd3) begin bad++; $display("FAIL rst_pre_alu_a got=%0h exp=3", bus.alu_a); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%0b exp=1", bus.busy); end
    rst = 1'b1; bus.req0 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++; if (bus.alu_a !== 16'h0 || bus.alu_b !== 16'h0) begin bad++; $display("FAIL rst_alu_ab got=%0h/%0h exp=0/0", bus.alu_a, bus.alu_b); end
      total++; if (bus.alu_opc !== 3'b000) begin bad++; $display("FAIL rst_alu_opc got=%0b exp=000", bus.alu_opc); end
      total++; if (bus.rsp_data !== 16'h0) begin bad++; $display("FAIL rst_rsp_data got=%0h exp=0", bus.rsp_data); end
      total++; if (bus.rsp_zero !== 1'b1) begin bad++; $display("FAIL rst_rsp_zero got=%0b exp=1", bus.rsp_zero); end
      total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL rst_rsp_id got=%0b exp=0", bus.rsp_id); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
      total++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack got=%0b%0b exp=00", bus.ack0, bus.ack1); end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle ack=%0b%0b busy=%0b exp=00/0", bus.ack0, bus.ack1, bus.busy); end
    end
  endtask
  task automatic test_single_add();
    bus.req0 = 1'b1; bus.opc0 = 3'b010; bus.a0 = 16'd3; bus.b0 = 16'd5;
    @(negedge clk);
    total++; if (bus.alu_opc !== 3'b010) begin bad++; $display("FAIL add_alu_opc got=%0b exp=010", bus.alu_opc); end
    total++; if (bus.busy !== 1'b1 || bus.ack0 !== 1'b0) begin bad++; $display("FAIL add_exec busy=%0b ack0=%0b exp=1/0", bus.busy, bus.ack0); end
    @(negedge clk);
    total++; if (bus.rsp_data !== 16'd8) begin bad++; $display("FAIL add_capture got=%0h exp=8", bus.rsp_data); end
    total++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL add_resp ack=%0b%0b busy=%0b exp=00/1", bus.ack0, bus.ack1, bus.busy); end
    @(negedge clk);
    total++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin bad++; $display("FAIL add_ack got=%0b%0b exp=10", bus.ack0, bus.ack1); end
    total++; if (bus.rsp_data !== 16'd8 || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b0) begin bad++; $display("FAIL add_rsp data=%0h zero=%0b id=%0b exp=8/0/0", bus.rsp_data, bus.rsp_zero, bus.rsp_id); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL add_busy_idle got=%0b exp=0", bus.busy); end
    bus.req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin bad++; $display("FAIL add_after ack=%0b%0b exp=00", bus.ack0, bus.ack1); end
    end
  endtask
  task automatic test_contention();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b1; bus.opc0 = 3'b011; bus.a0 = 16'd5; bus.b0 = 16'd5;
    bus.req1 = 1'b1; bus.opc1 = 3'b010; bus.a1 = 16'hFFFF; bus.b1 = 16'd1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      total++; if (bus.ack0 !== (c % 6 == 3) || bus.ack1 !== (c % 6 == 0)) begin bad++; $display("FAIL cont_ack c=%0d got=%0b%0b exp=%0b%0b", c, bus.ack0, bus.ack1, c % 6 == 3, c % 6 == 0); end
      if (c % 3 == 0) begin
        total++; if (bus.rsp_data !== 16'h0 || bus.rsp_zero !== 1'b1 || bus.rsp_id !== (c % 6 == 0)) begin bad++; $display("FAIL cont_rsp c=%0d data=%0h zero=%0b id=%0b exp=0/1/%0b", c, bus.rsp_data, bus.rsp_zero, bus.rsp_id, c % 6 == 0); end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++; if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL cont_drain ack=%0b%0b busy=%0b exp=00/0", bus.ack0, bus.ack1, bus.busy); end
    end
  endtask
  task automatic test_readback();
    bus.req1 = 1'b1; bus.opc1 = 3'b101; bus.a1 = 16'h00F0; bus.b1 = 16'h0F00;
    repeat (3) @(negedge clk);
    total++; if (bus.ack1 !== 1'b1 || bus.rsp_data !== 16'h0FF0) begin bad++; $display("FAIL rb_or ack1=%0b data=%0h exp=1/0ff0", bus.ack1, bus.rsp_data); end
    bus.req1 = 1'b0;
    bus.req0 = 1'b1; bus.opc0 = 3'b111; bus.a0 = 16'h1234; bus.b0 = 16'h0;
    repeat (3) @(negedge clk);
    total++; if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin bad++; $display("FAIL rb_ack got=%0b%0b exp=10", bus.ack0, bus.ack1); end
    total++; if (bus.rsp_data !== 16'h0FF0 || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b0) begin bad++; $display("FAIL rb_rsp data=%0h zero=%0b id=%0b exp=0ff0/0/0", bus.rsp_data, bus.rsp_zero, bus.rsp_id); end
    bus.req0 = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_abort();
    bus.req1 = 1'b1; bus.opc1 = 3'b110; bus.a1 = 16'h0; bus.b1 = 16'h0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL ab_exec busy=%0b exp=1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.ack1 !== 1'b0) begin bad++; $display("FAIL ab_reset busy=%0b ack1=%0b exp=0/0", bus.busy, bus.ack1); end
    total++; if (bus.rsp_data !== 16'h0 || bus.rsp_zero !== 1'b1) begin bad++; $display("FAIL ab_rsp data=%0h zero=%0b exp=0/1", bus.rsp_data, bus.rsp_zero); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.ack1 !== 1'b0) begin bad++; $display("FAIL ab_regrant busy=%0b ack1=%0b exp=1/0", bus.busy, bus.ack1); end
    @(negedge clk);
    total++; if (bus.ack1 !== 1'b0 || bus.rsp_data !== 16'hFFFF) begin bad++; $display("FAIL ab_capture ack1=%0b data=%0h exp=0/ffff", bus.ack1, bus.rsp_data); end
    @(negedge clk);
    total++; if (bus.ack1 !== 1'b1 || bus.rsp_data !== 16'hFFFF || bus.rsp_zero !== 1'b0 || bus.rsp_id !== 1'b1) begin bad++; $display("FAIL ab_ack ack1=%0b data=%0h zero=%0b id=%0b exp=1/ffff/0/1", bus.ack1, bus.rsp_data, bus.rsp_zero, bus.rsp_id); end
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_late_withdraw();
    bus.req0 = 1'b1; bus.opc0 = 3'b001; bus.a0 = 16'd7; bus.b0 = 16'h0;
    @(negedge clk);
    bus.req1 = 1'b1; bus.opc1 = 3'b000; bus.a1 = 16'h0; bus.b1 = 16'h0055;
    repeat (2) @(negedge clk);
    total++; if (bus.ack0 !== 1'b1 || bus.rsp_data !== 16'd7) begin bad++; $display("FAIL lw_ack0 ack0=%0b data=%0h exp=1/7", bus.ack0, bus.rsp_data); end
    bus.req0 = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.alu_opc !== 3'b000 || bus.alu_b !== 16'h0055) begin bad++; $display("FAIL lw_late_grant busy=%0b opc=%0b b=%0h exp=1/000/0055", bus.busy, bus.alu_opc, bus.alu_b); end
    repeat (2) @(negedge clk);
    total++; if (bus.ack1 !== 1'b1 || bus.rsp_data !== 16'h0055 || bus.rsp_id !== 1'b1) begin bad++; $display("FAIL lw_ack1 ack1=%0b data=%0h id=%0b exp=1/0055/1", bus.ack1, bus.rsp_data, bus.rsp_id); end
    bus.opc1 = 3'b001; bus.a1 = 16'd9;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1 || bus.alu_a !== 16'd9) begin bad++; $display("FAIL lw_rerequest busy=%0b a=%0h exp=1/9", bus.busy, bus.alu_a); end
    bus.req0 = 1'b1; bus.opc0 = 3'b010; bus.a0 = 16'd1; bus.b0 = 16'd1;
    @(negedge clk);
    bus.req0 = 1'b0;
    @(negedge clk);
    total++; if (bus.ack1 !== 1'b1 || bus.rsp_data !== 16'd9) begin bad++; $display("FAIL lw_ack1b ack1=%0b data=%0h exp=1/9", bus.ack1, bus.rsp_data); end
    bus.req1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL lw_withdrawn ack0=%0b busy=%0b exp=0/0", bus.ack0, bus.busy); end
    end
  endtask
  initial begin
    bus.req0 = 1'b0; bus.opc0 = 3'b000; bus.a0 = 16'h0; bus.b0 = 16'h0;
    bus.req1 = 1'b0; bus.opc1 = 3'b000; bus.a1 = 16'h0; bus.b1 = 16'h0;
    test_reset();
    test_single_add();
    test_contention();
    test_readback();
    test_abort();
    test_late_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
